// File: rtl/dcache_pkg.sv
// Shared DRAM-cache types: geometry, fill request and tag metadata layouts,
// and the fill arbiter state encoding.
package dcache_pkg;

  localparam int ADDR_WIDTH   = 64;
  localparam int DATA_WIDTH   = 512;
  localparam int ID_WIDTH     = 4;
  localparam int INDEX_WIDTH  = 10;
  localparam int OFFSET_WIDTH = 6;
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int BLANK_WIDTH  = 14;
  localparam int TAG_SIZE     = 2 + TAG_WIDTH + BLANK_WIDTH;
  localparam int SET_WIDTH    = INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic {
    SRC_W = 1'b0,
    SRC_R = 1'b1
  } fill_src_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } fill_req_t;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [TAG_WIDTH-1:0]   tag;
    logic [BLANK_WIDTH-1:0] blank;
  } tag_meta_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } arb_state_e;

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
    return TAG_WIDTH'(addr >> SET_WIDTH);
  endfunction

  // The DRAM cache is addressed by set only; the tag travels in the metadata word.
  function automatic logic [ADDR_WIDTH-1:0] set_addr(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~{{TAG_WIDTH{1'b1}}, {SET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/fill_rr_arb.sv
// Two-input round-robin arbiter; priority flips only after a contended grant.
module fill_rr_arb
  import dcache_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  fill_src_e rr;

  // NOTE: every signal driven from always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (rr == SRC_W) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rr <= SRC_W;
    else if (en && (req == 2'b11)) rr <= (rr == SRC_W) ? SRC_R : SRC_W;
  end

endmodule

// File: rtl/fill_arbiter.sv
// Arbitrates write fills (port W) and read refills (port R) onto one AXI AW+W
// beat to the DRAM-cache controller, with a credit limit on outstanding B.
module fill_arbiter
  import dcache_pkg::*;
#(
  parameter logic [ID_WIDTH-1:0] AW_ID     = '0,
  parameter int unsigned         MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_data_i,
  input  logic                           rf_valid_i,
  output logic                           rf_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] rf_data_i,
  output logic [ID_WIDTH-1:0]            awid_o,
  output logic [ADDR_WIDTH-1:0]          awaddr_o,
  output logic                           awvalid_o,
  input  logic                           awready_i,
  output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
  output logic                           wlast_o,
  output logic                           wvalid_o,
  input  logic                           wready_i,
  input  logic                           bvalid_i,
  input  logic [1:0]                     bresp_i,
  output logic                           bready_o,
  output logic                           err_o,
  output logic                           idle_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  arb_state_e    state, state_nxt;
  fill_req_t     req_q;
  tag_meta_t     meta;
  logic          dirty_q, aw_done, w_done, bready_q, err_q;
  logic [CW-1:0] outst;
  logic [1:0]    gnt;
  logic          grant_en, accept, fill_done, b_hs, outst_inc, outst_dec;

  assign grant_en = (state == S_IDLE) && (outst < CW'(MAX_OUTST));
  assign accept   = |gnt;

  fill_rr_arb u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({rf_valid_i, wr_valid_i}),
    .en    (grant_en),
    .gnt   (gnt)
  );

  assign wr_ready_o = gnt[SRC_W];
  assign rf_ready_o = gnt[SRC_R];

  // A side already done counts as complete; AW and W may finish in any order.
  assign fill_done = (state == S_SEND) && (aw_done || awready_i) && (w_done || wready_i);
  assign b_hs      = bvalid_i && bready_q;
  assign outst_inc = fill_done;
  assign outst_dec = b_hs && (outst != '0);

  always_comb begin
    state_nxt = state;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SEND;
      S_SEND: begin
        awvalid_o = !aw_done;
        wvalid_o  = !w_done;
        if (fill_done) state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      outst    <= '0;
      err_q    <= 1'b0;
      bready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bready_q <= 1'b1;
      if (fill_done) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_SEND) begin
        aw_done <= aw_done || awready_i;
        w_done  <= w_done || wready_i;
      end
      if (outst_inc != outst_dec) outst <= outst_inc ? outst + 1'b1 : outst - 1'b1;
      if (b_hs && (bresp_i != 2'b00)) err_q <= 1'b1;
    end
  end

  // NOTE: the wide line register is reset as well, so the AW/W buses never
  // carry X even before the first fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      dirty_q <= 1'b0;
    end else if (accept) begin
      req_q   <= gnt[SRC_W] ? fill_req_t'(wr_data_i) : fill_req_t'(rf_data_i);
      dirty_q <= gnt[SRC_W];
    end
  end

  assign meta = '{valid: 1'b1, dirty: dirty_q, tag: addr_tag(req_q.addr), blank: '0};

  assign awid_o   = AW_ID;
  assign awaddr_o = set_addr(req_q.addr);
  assign wdata_o  = {meta, req_q.data};
  assign wlast_o  = wvalid_o;
  assign bready_o = bready_q;
  assign err_o    = err_q;
  assign idle_o   = (state == S_IDLE) && (outst == '0);

endmodule

// File: tb/tb_fill_arbiter.sv
// Randomized scoreboard bench for fill_arbiter with directed credit, stall,
// error-response and mid-transfer reset scenarios.
`timescale 1ns/1ps
module tb_fill_arbiter;
  import dcache_pkg::*;

  localparam int                    MAX_OUTST = 4;
  localparam logic [ID_WIDTH-1:0]   AW_ID     = 4'h3;
  localparam int                    WW        = TAG_SIZE + DATA_WIDTH;
  localparam int                    SETW      = INDEX_WIDTH + OFFSET_WIDTH;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } item_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_valid = 1'b0, rf_valid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr = '0, rf_addr = '0;
  logic [DATA_WIDTH-1:0] wr_dat = '0, rf_dat = '0;
  logic [1:0] bresp = 2'b00;
  logic wr_ready, rf_ready, awvalid, wlast, wvalid, bready, err, idle;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [WW-1:0]         wdata;

  fill_arbiter #(.AW_ID(AW_ID), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i({wr_addr, wr_dat}),
    .rf_valid_i(rf_valid), .rf_ready_o(rf_ready), .rf_data_i({rf_addr, rf_dat}),
    .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bvalid_i(bvalid), .bresp_i(bresp), .bready_o(bready), .err_o(err), .idle_o(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] rand_data();
    logic [DATA_WIDTH-1:0] d;
    for (int i = 0; i < DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.addr = {$urandom, $urandom};
    it.data = rand_data();
    return it;
  endfunction

  // Reference: DRAM-cache address is the byte address modulo the set span.
  function automatic logic [ADDR_WIDTH-1:0] exp_awaddr(input logic [ADDR_WIDTH-1:0] a);
    return a % (ADDR_WIDTH'(1) << SETW);
  endfunction

  // Reference metadata: valid at the top bit, dirty below it, tag above the blank field.
  function automatic logic [WW-1:0] exp_wdata(input logic [ADDR_WIDTH-1:0] a, input logic dirty,
                                              input logic [DATA_WIDTH-1:0] d);
    logic [TAG_SIZE-1:0] m;
    m = (TAG_SIZE'(1) << (TAG_SIZE - 1)) | (TAG_SIZE'(dirty) << (TAG_SIZE - 2))
      | (TAG_SIZE'(a / (ADDR_WIDTH'(1) << SETW)) << BLANK_WIDTH);
    return {m, d};
  endfunction

  // Stimulus knobs (percent probabilities) and request queues.
  int p_wr = 0, p_rf = 0, p_aw = 0, p_w = 0, p_b = 0, p_berr = 0;
  bit b_force = 0;
  logic [1:0] b_force_resp = 2'b00;
  item_t wq[$], rq[$];
  bit w_taken = 0, r_taken = 0;
  int n_wacc = 0, n_racc = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      wr_valid = 1'b0; rf_valid = 1'b0; w_taken = 0; r_taken = 0;
    end else begin
      if (w_taken) begin wr_valid = 1'b0; w_taken = 0; end
      if (r_taken) begin rf_valid = 1'b0; r_taken = 0; end
      if (!wr_valid && wq.size() > 0 && $urandom_range(99) < p_wr) begin
        item_t it;
        it = wq.pop_front();
        wr_addr = it.addr; wr_dat = it.data; wr_valid = 1'b1;
      end
      if (!rf_valid && rq.size() > 0 && $urandom_range(99) < p_rf) begin
        item_t it;
        it = rq.pop_front();
        rf_addr = it.addr; rf_dat = it.data; rf_valid = 1'b1;
      end
    end
    awready = ($urandom_range(99) < p_aw);
    wready  = ($urandom_range(99) < p_w);
    if (b_force) begin
      bvalid = 1'b1; bresp = b_force_resp; b_force = 0;
    end else begin
      bvalid = ($urandom_range(99) < p_b);
      bresp  = ($urandom_range(99) < p_berr) ? 2'($urandom_range(3, 1)) : 2'b00;
    end
  end

  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin w_taken = 1; n_wacc++; end
    if (rst_n && rf_valid && rf_ready) begin r_taken = 1; n_racc++; end
  end

  // Behavioural model: fill-in-flight flag, credit count, priority and sticky error.
  logic [ADDR_WIDTH-1:0] exp_aw[$];
  logic [WW-1:0]         exp_w[$];
  bit m_send, m_awd, m_wd, m_rr, m_err, m_bready;
  bit can, gw, gr, a_now, w_now, inc, dec;
  int m_outst;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_send = 0; m_awd = 0; m_wd = 0; m_rr = 0; m_err = 0; m_bready = 0; m_outst = 0;
      exp_aw.delete(); exp_w.delete();
    end else begin
      check("awvalid", awvalid, m_send && !m_awd);
      check("wvalid", wvalid, m_send && !m_wd);
      check("wlast", wlast, m_send && !m_wd);
      check("bready", bready, m_bready);
      check("err", err, m_err);
      check("idle", idle, !m_send && m_outst == 0);
      can = !m_send && (m_outst < MAX_OUTST);
      gw  = can && wr_valid && (!rf_valid || !m_rr);
      gr  = can && rf_valid && (!wr_valid || m_rr);
      check("wr_ready", wr_ready, gw);
      check("rf_ready", rf_ready, gr);
      inc = 0;
      if (gw || gr) begin
        exp_aw.push_back(exp_awaddr(gw ? wr_addr : rf_addr));
        exp_w.push_back(gw ? exp_wdata(wr_addr, 1'b1, wr_dat) : exp_wdata(rf_addr, 1'b0, rf_dat));
        m_send = 1; m_awd = 0; m_wd = 0;
        if (wr_valid && rf_valid) m_rr = !m_rr;
      end else if (m_send) begin
        a_now = m_awd || awready;
        w_now = m_wd || wready;
        if (a_now && w_now) begin m_send = 0; inc = 1; end
        else begin m_awd = a_now; m_wd = w_now; end
      end
      dec = bvalid && m_bready && (m_outst != 0);
      if (bvalid && m_bready && bresp != 2'b00) m_err = 1;
      m_outst = m_outst + int'(inc) - int'(dec);
      m_bready = 1;
    end
  end

  // Monitor: compares each presented AW/W beat against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (awvalid) begin
        if (exp_aw.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL aw_unexpected: awaddr %0h with no fill expected", awaddr);
        end else begin
          check("awaddr", awaddr, exp_aw[0]);
          check("awid", awid, AW_ID);
          if (awready) void'(exp_aw.pop_front());
        end
      end
      if (wvalid) begin
        if (exp_w.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w_unexpected: wdata %0h with no fill expected", wdata);
        end else begin
          check("wdata", wdata, exp_w[0]);
          if (wready) void'(exp_w.pop_front());
        end
      end
    end
  end

  task automatic wait_acc(input string name, input int want_w, input int want_r, input int budget);
    for (int i = 0; i < budget && (n_wacc < want_w || n_racc < want_r); i++) begin
      @(negedge clk); #1;
    end
    check({name, "_w_accepts"}, n_wacc, want_w);
    check({name, "_r_accepts"}, n_racc, want_r);
  endtask

  task automatic drain(input string name);
    p_wr = 100; p_rf = 100; p_aw = 100; p_w = 100; p_b = 100; p_berr = 0;
    for (int i = 0; i < 500 && !(idle && wq.size() == 0 && rq.size() == 0 && !wr_valid && !rf_valid); i++)
      @(negedge clk);
    @(negedge clk); #1;
    check({name, "_idle"}, idle, 1'b1);
    check({name, "_aw_left"}, exp_aw.size(), 0);
    check({name, "_w_left"}, exp_w.size(), 0);
    p_b = 0;
  endtask

  initial begin
    int base;
    logic seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rf_ready", rf_ready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_idle", idle, 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;

    // Port W only, fixed address and data pattern
    p_wr = 100; p_rf = 100; p_aw = 100; p_w = 100; p_b = 0;
    wq.push_back('{64'h0000_1234_5678_9A40, {(DATA_WIDTH/8){8'hAA}}});
    wait_acc("t1", 1, 0, 20);
    repeat (4) @(negedge clk);

    // Both ports contending every cycle: strict alternation
    for (int i = 0; i < 6; i++) begin wq.push_back(rand_item()); rq.push_back(rand_item()); end
    p_b = 100;
    wait_acc("t2", n_wacc + 6, n_racc + 6, 100);
    drain("t2");

    // Credit limit
    base = n_wacc;
    for (int i = 0; i < 6; i++) wq.push_back(rand_item());
    p_b = 0;
    repeat (30) @(negedge clk);
    #1 check("t3_credit_fills", n_wacc - base, 4);
    b_force_resp = 2'b00; b_force = 1;
    repeat (20) @(negedge clk);
    #1 check("t3_after_b_fills", n_wacc - base, 5);
    drain("t3");

    // W accepted three cycles after AW
    p_w = 0; p_aw = 100;
    wq.push_back(rand_item());
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = wvalid; end
    check("t4_wvalid_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    p_w = 100;
    @(negedge clk);
    check("t4_wvalid_4th", wvalid, 1'b1);
    check("t4_awvalid_dropped", awvalid, 1'b0);
    @(negedge clk);
    check("t4_wvalid_done", wvalid, 1'b0);
    drain("t4");

    // Error B response coinciding with a fill completion
    wq.push_back(rand_item());
    wait_acc("t5a", n_wacc + 1, n_racc, 20);
    repeat (4) @(negedge clk);
    wq.push_back(rand_item());
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = wr_valid && wr_ready; end
    check("t5_accept_seen", seen, 1'b1);
    b_force_resp = 2'b10; b_force = 1;
    repeat (3) @(negedge clk);
    check("t5_err", err, 1'b1);
    check("t5_outst_kept", idle, 1'b0);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", err, 1'b1);
    drain("t5");

    // Reset in the middle of a send
    p_aw = 0; p_w = 0;
    wq.push_back(rand_item());
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = awvalid; end
    check("t6_awvalid_seen", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_awvalid", awvalid, 1'b0);
    check("t6_rst_wvalid", wvalid, 1'b0);
    check("t6_rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    check("t6_idle_after", idle, 1'b1);

    // Randomized traffic
    for (int seg = 0; seg < 10; seg++) begin
      p_wr = $urandom_range(100, 20); p_rf = $urandom_range(100, 20);
      p_aw = $urandom_range(100, 30); p_w = $urandom_range(100, 30);
      p_b = $urandom_range(80, 10); p_berr = 5;
      repeat (150) begin
        @(negedge clk);
        if (wq.size() < 2) wq.push_back(rand_item());
        if (rq.size() < 2) rq.push_back(rand_item());
      end
    end
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
